// File: rtl/alu_exec_unit.sv
// RV32I register-register execute stage with valid/ready handshake on both sides.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter; otherwise shifts run one bit per cycle.
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              alu_base_enable,
  input  logic              alu_extra_enable,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   operand_a,
  input  logic [XLEN-1:0]   operand_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              illegal
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready=1
  // SHIFT | serial shift in progress, one bit per cycle (serial build only)
  // DONE  | result/illegal presented, waiting for out_ready
`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t              state;
  logic [SHAMT_W-1:0]  shamt;
  logic                op_legal;
  logic                op_right;
  logic                op_arith;
  logic [XLEN-1:0]     op_value;
  logic [XLEN-1:0]     shift_value;

  assign shamt    = operand_b[SHAMT_W-1:0];
  assign op_right = (funct3 == 3'b101);
  assign op_arith = alu_extra_enable;

`ifdef ALU_FAST_SHIFT_EN
  always_comb begin
    if (!op_right)
      shift_value = operand_a << shamt;
    else if (op_arith)
      shift_value = $unsigned($signed(operand_a) >>> shamt);
    else
      shift_value = operand_a >> shamt;
  end
`else
  logic                op_shift;
  logic [XLEN-1:0]     sh_q;
  logic [XLEN-1:0]     sh_next;
  logic [SHAMT_W-1:0]  cnt_q;
  logic                right_q;
  logic                arith_q;

  // Only a zero shamt completes directly from IDLE, so the shifted value is operand_a itself.
  assign shift_value = operand_a;
  assign op_shift    = (funct3[1:0] == 2'b01);
  assign sh_next     = right_q ? {arith_q & sh_q[XLEN-1], sh_q[XLEN-1:1]}
                               : {sh_q[XLEN-2:0], 1'b0};
`endif

  always_comb begin
    op_legal = 1'b0;
    op_value = '0;
    if (alu_base_enable && !alu_extra_enable) begin
      op_legal = 1'b1;
      case (funct3)
        3'b000:  op_value = operand_a + operand_b;
        3'b001:  op_value = shift_value;
        3'b010:  op_value = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
        3'b011:  op_value = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
        3'b100:  op_value = operand_a ^ operand_b;
        3'b101:  op_value = shift_value;
        3'b110:  op_value = operand_a | operand_b;
        default: op_value = operand_a & operand_b;
      endcase
    end else if (alu_extra_enable && !alu_base_enable) begin
      case (funct3)
        3'b000: begin
          op_legal = 1'b1;
          op_value = operand_a - operand_b;
        end
        3'b101: begin
          op_legal = 1'b1;
          op_value = shift_value;
        end
        default: op_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      sh_q      <= '0;
      cnt_q     <= '0;
      right_q   <= 1'b0;
      arith_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (!op_legal) begin
              result    <= '0;
              illegal   <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end
`ifndef ALU_FAST_SHIFT_EN
            else if (op_shift && (shamt != '0)) begin
              sh_q    <= operand_a;
              cnt_q   <= shamt;
              right_q <= op_right;
              arith_q <= op_arith;
              illegal <= 1'b0;
              state   <= SHIFT;
            end
`endif
            else begin
              result    <= op_value;
              illegal   <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        SHIFT: begin
          sh_q  <= sh_next;
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result    <= sh_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed vector bench for alu_exec_unit; also covers backpressure and reset during an operation.
module tb_alu_exec_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        alu_base_enable;
  logic        alu_extra_enable;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .alu_base_enable  (alu_base_enable),
    .alu_extra_enable (alu_extra_enable),
    .funct3           (funct3),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .illegal          (illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        base;
    logic        extra;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_illegal;
    int          serial_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic bs, logic ex, logic [2:0] f, logic [31:0] a,
                              logic [31:0] b, logic [31:0] r, logic il, int lat);
    vec_t v;
    v.name = nm; v.base = bs; v.extra = ex; v.f3 = f; v.a = a; v.b = b;
    v.exp_result = r; v.exp_illegal = il; v.serial_lat = lat;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic drive_op(input logic bs, input logic ex, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b);
    alu_base_enable  = bs;
    alu_extra_enable = ex;
    funct3           = f;
    operand_a        = a;
    operand_b        = b;
    in_valid         = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int   lat;
    int   exp_lat;
    logic busy_ready;
`ifdef ALU_FAST_SHIFT_EN
    exp_lat = 1;
`else
    exp_lat = v.serial_lat;
`endif
    @(negedge clock);
    drive_op(v.base, v.extra, v.f3, v.a, v.b);
    out_ready = 1'b1;
    check({v.name, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid   = 1'b0;
    operand_a  = 32'hDEAD_BEEF;
    operand_b  = 32'h0000_0007;
    lat        = 1;
    busy_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ready = 1'b1;
      @(posedge clock); #1;
      lat++;
    end
    check({v.name, "_latency"},   lat,                     exp_lat);
    check({v.name, "_result"},    result,                  v.exp_result);
    check({v.name, "_illegal"},   {31'b0, illegal},        {31'b0, v.exp_illegal});
    check({v.name, "_busy_ready"}, {31'b0, busy_ready | in_ready}, 32'd0);
    @(posedge clock); #1;
    check({v.name, "_drop_valid"}, {31'b0, out_valid}, 32'd0);
    check({v.name, "_ready_back"}, {31'b0, in_ready},  32'd1);
  endtask

  initial begin
    logic rose;

    vecs.push_back(mk("add_wrap",   1, 0, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 1));
    vecs.push_back(mk("sub_neg",    0, 1, 3'b000, 32'd5,         32'd7,         32'hFFFF_FFFE, 0, 1));
    vecs.push_back(mk("slt_neg",    1, 0, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 1));
    vecs.push_back(mk("sltu_big",   1, 0, 3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 1));
    vecs.push_back(mk("slt_pos",    1, 0, 3'b010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1));
    vecs.push_back(mk("sltu_small", 1, 0, 3'b011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1));
    vecs.push_back(mk("xor",        1, 0, 3'b100, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 0, 1));
    vecs.push_back(mk("or",         1, 0, 3'b110, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0, 1));
    vecs.push_back(mk("and",        1, 0, 3'b111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0, 1));
    vecs.push_back(mk("sra_31",     0, 1, 3'b101, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 0, 32));
    vecs.push_back(mk("sll_0",      1, 0, 3'b001, 32'h0000_0001, 32'd0,         32'h0000_0001, 0, 1));
    vecs.push_back(mk("sll_4",      1, 0, 3'b001, 32'h0000_0001, 32'd4,         32'h0000_0010, 0, 5));
    vecs.push_back(mk("srl_4",      1, 0, 3'b101, 32'h8000_0000, 32'd4,         32'h0800_0000, 0, 5));
    vecs.push_back(mk("sra_4",      0, 1, 3'b101, 32'h8000_0000, 32'd4,         32'hF800_0000, 0, 5));
    vecs.push_back(mk("sra_hi_b",   0, 1, 3'b101, 32'h7000_0000, 32'hFFFF_FFE3, 32'h0E00_0000, 0, 4));
    vecs.push_back(mk("ill_extra",  0, 1, 3'b001, 32'd5,         32'd3,         32'h0000_0000, 1, 1));
    vecs.push_back(mk("ill_both",   1, 1, 3'b000, 32'd5,         32'd3,         32'h0000_0000, 1, 1));
    vecs.push_back(mk("ill_none",   0, 0, 3'b000, 32'd5,         32'd3,         32'h0000_0000, 1, 1));

    // Reset held with a pending request: nothing may be accepted.
    reset     = 1'b1;
    out_ready = 1'b1;
    drive_op(1'b1, 1'b0, 3'b000, 32'd1, 32'd2);
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_illegal",   {31'b0, illegal},   32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clock); #1;
    check("post_rst_idle", {31'b0, out_valid}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result must hold while out_ready is low.
    @(negedge clock);
    drive_op(1'b1, 1'b0, 3'b111, 32'hFF00_FF00, 32'h0FF0_0FF0);
    out_ready = 1'b0;
    @(posedge clock); #1;
    in_valid  = 1'b0;
    operand_a = 32'h0;
    check("bp_valid_first", {31'b0, out_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check("bp_hold_valid",  {31'b0, out_valid}, 32'd1);
      check("bp_hold_result", result,             32'h0F00_0F00);
      check("bp_hold_ready",  {31'b0, in_ready},  32'd0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_release_valid", {31'b0, out_valid}, 32'd0);
    check("bp_release_ready", {31'b0, in_ready},  32'd1);

    // Reset during a serial SRL by 20 (or with the result pending in the fast build).
    @(negedge clock);
    drive_op(1'b1, 1'b0, 3'b101, 32'hFFFF_FFFF, 32'd20);
    @(posedge clock); #1;
    in_valid = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
    repeat (5) @(posedge clock);
`endif
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_in_ready",  {31'b0, in_ready},  32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_result",    result,             32'd0);
    @(negedge clock);
    reset = 1'b0;
    rose  = 1'b0;
    repeat (30) begin
      @(posedge clock); #1;
      if (out_valid) rose = 1'b1;
    end
    check("midrst_never_valid", {31'b0, rose}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
